// File: rtl/ifetch_queue.sv
// Instruction fetch queue: sequential fetch-PC requests to a 1-cycle imem, DEPTH-entry {pc,instr} FIFO, redirect flush.
// Optional same-cycle bypass of the response to decode when the queue is empty: define IFQ_BYPASS_EN.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

module ifetch_queue #(
    parameter int                      DEPTH    = 4,
    parameter logic [`ADDR_SIZE-1:0]   RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        imem_req,
    output logic [`ADDR_SIZE-1:0]       imem_addr,
    input  logic [`INSTR_SIZE-1:0]      imem_rdata,
    input  logic                        redirect_i,
    input  logic [`ADDR_SIZE-1:0]       redirect_pc_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [`INSTR_SIZE-1:0]      instr_o,
    output logic [`ADDR_SIZE-1:0]       pc_o,
    output logic [`ADDR_SIZE-1:0]       pcplus4_o,
    output logic [$clog2(DEPTH):0]      count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [`INSTR_SIZE-1:0] NOP = 32'h0000_0013;

    logic [`ADDR_SIZE-1:0]  fpc_q, fpc_d;
    logic [`ADDR_SIZE-1:0]  ipc_q;
    logic                   inflight_q, inflight_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [`ADDR_SIZE-1:0]  fifo_pc_q    [DEPTH];
    logic [`INSTR_SIZE-1:0] fifo_instr_q [DEPTH];

    logic [CW:0] used;
    logic        head_vld, byp_vld, push, pop;

    // Credit counts the in-flight response so a push can never land on a full FIFO.
    assign used      = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign imem_req  = !reset && !redirect_i && (used < (CW+1)'(DEPTH));
    assign imem_addr = fpc_q;
    assign head_vld  = (count_q != '0);

`ifdef IFQ_BYPASS_EN
    assign byp_vld = !head_vld && inflight_q;
`else
    assign byp_vld = 1'b0;
`endif

    assign push = inflight_q && !redirect_i && !(byp_vld && ready_i);
    assign pop  = head_vld && ready_i && !redirect_i;

    always_comb begin
        fpc_d      = fpc_q;
        inflight_d = imem_req;
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
        if (imem_req) begin
            fpc_d = fpc_q + `ADDR_SIZE'(4);
        end
        if (redirect_i) begin
            fpc_d    = redirect_pc_i & ~`ADDR_SIZE'(3);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q      <= RESET_PC;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fpc_q      <= fpc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) begin
            ipc_q <= fpc_q;
        end
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= ipc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && count_q == CW'(DEPTH)));
        end
    end

    always_comb begin
        valid_o   = head_vld || byp_vld;
        instr_o   = NOP;
        pc_o      = '0;
        pcplus4_o = '0;
        if (head_vld) begin
            instr_o = fifo_instr_q[rd_ptr_q];
            pc_o    = fifo_pc_q[rd_ptr_q];
        end else if (byp_vld) begin
            instr_o = imem_rdata;
            pc_o    = ipc_q;
        end
        if (valid_o) begin
            pcplus4_o = pc_o + `ADDR_SIZE'(4);
        end
    end

    assign count_o = count_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: vector table of hand-derived cycles plus randomized traffic against a queue-based model.
module tb_ifetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] instr_o, pc_o, pcplus4_o;
    logic [2:0]  count_o;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    int checks = 0;
    int errors = 0;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .pc_o(pc_o),
        .pcplus4_o(pcplus4_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: content is address ^ KEY.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ KEY;
    end

    typedef struct {
        logic        rst;
        logic        red;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t tbl [21];
    vec_t none;

    // Reference model: a queue of PCs, one pending response, and the fetch PC.
    logic [31:0] mq [$];
    logic        m_inf;
    logic [31:0] m_ipc;
    logic [31:0] m_fpc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic red, input logic [31:0] rpc, input logic rdy,
                        input bit mchk, input bit tchk, input vec_t v);
        logic        m_vld, m_req, byp;
        logic [31:0] m_head;
        reset = r; redirect_i = red; redirect_pc_i = rpc; ready_i = rdy;
        @(negedge clk);
        m_vld  = (mq.size() > 0);
        m_head = m_vld ? mq[0] : 32'h0;
        byp    = 1'b0;
`ifdef IFQ_BYPASS_EN
        if (!m_vld && m_inf) begin
            m_vld = 1'b1; m_head = m_ipc; byp = 1'b1;
        end
`endif
        m_req = !r && !red && ((mq.size() + int'(m_inf)) < 4);
        if (mchk) begin
            chk("m_req", 32'(imem_req), 32'(m_req));
            chk("m_addr", imem_addr, m_fpc);
            chk("m_valid", 32'(valid_o), 32'(m_vld));
            chk("m_count", 32'(count_o), 32'(mq.size()));
            chk("m_pc", pc_o, m_vld ? m_head : 32'h0);
            chk("m_instr", instr_o, m_vld ? (m_head ^ KEY) : NOP);
            chk("m_pcplus4", pcplus4_o, m_vld ? (m_head + 32'd4) : 32'h0);
        end
        if (tchk) begin
            chk("t_req", 32'(imem_req), 32'(v.e_req));
            chk("t_addr", imem_addr, v.e_addr);
            chk("t_valid", 32'(valid_o), 32'(v.e_vld));
            chk("t_pc", pc_o, v.e_pc);
            chk("t_count", 32'(count_o), 32'(v.e_cnt));
            chk("t_instr", instr_o, v.e_vld ? (v.e_pc ^ KEY) : NOP);
            chk("t_pcplus4", pcplus4_o, v.e_vld ? (v.e_pc + 32'd4) : 32'h0);
        end
        if (r) begin
            mq.delete(); m_inf = 1'b0; m_fpc = 32'h0;
        end else if (red) begin
            mq.delete(); m_inf = 1'b0; m_fpc = {rpc[31:2], 2'b00};
        end else begin
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (m_inf && !(byp && rdy)) mq.push_back(m_ipc);
            m_inf = m_req;
            if (m_req) begin
                m_ipc = m_fpc;
                m_fpc = m_fpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        none = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 0};
        //          rst  red  rpc        rdy  req  addr       vld  pc         cnt
        tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   1'b0, 32'h0,   0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   1'b0, 32'h0,   0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   1'b1, 32'h0,   1};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'hC,   1'b1, 32'h0,   2};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 32'h0,   3};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 32'h0,   4};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 32'h0,   4};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h10,  1'b1, 32'h0,   4};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'h4,   3};
        tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h14,  1'b1, 32'h8,   2};
        tbl[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h18,  1'b1, 32'hC,   2};
        tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h1C,  1'b1, 32'h10,  2};
        tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h20,  1'b1, 32'h14,  2};
        tbl[14] = '{1'b0, 1'b1, 32'h103, 1'b1, 1'b0, 32'h24,  1'b1, 32'h18,  2};
        tbl[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   0};
        tbl[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   0};
        tbl[17] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 1};
        tbl[18] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10C, 1'b1, 32'h104, 1};
        tbl[19] = '{1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h110, 1'b1, 32'h104, 2};
        tbl[20] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   0};

        m_inf = 1'b0; m_ipc = 32'h0; m_fpc = 32'h0;
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, none);

        for (int i = 0; i < 21; i++) begin
`ifndef IFQ_BYPASS_EN
            step(tbl[i].rst, tbl[i].red, tbl[i].rpc, tbl[i].rdy, 1'b1, 1'b1, tbl[i]);
`else
            step(tbl[i].rst, tbl[i].red, tbl[i].rpc, tbl[i].rdy, 1'b1, 1'b0, tbl[i]);
`endif
        end

        // Three queued entries plus one in flight, then redirect to 0x100.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, none);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, none);
        step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, none);
        chk("redir_count", 32'(count_o), 32'h0);
        chk("redir_addr", imem_addr, 32'h100);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, none);
            if (valid_o && !seen) begin
                seen = 1'b1;
                chk("redir_first_pc", pc_o, 32'h100);
            end
        end
        chk("redir_first_seen", 32'(seen), 32'h1);

        for (int i = 0; i < 200; i++) begin
            step(($urandom % 50) == 0, ($urandom % 12) == 0, $urandom & 32'h0000_3FFF,
                 ($urandom % 4) != 0, 1'b1, 1'b0, none);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
